// File: rtl/net_div_pipe.sv
// net_div_pipe: fully pipelined restoring integer divider (quotient + remainder).
//
// Operation: stage 0 registers the operand magnitudes, the sign flags, the
// divide-by-zero flag and the tag. Stage j (j >= 1) resolves DW/N_PIPE
// quotient bits, MSB first. The output register resolves the last group of
// bits and applies the sign fixup. A result therefore appears N_PIPE edges
// after acceptance. The whole pipe freezes while a result is held at the
// output with m_ready_i low.
//
// Ports:
//   clk_i          clock
//   rst_ni         synchronous active-low reset
//   s_valid_i      operation valid
//   s_ready_o      divider accepts an operation this cycle (= pipe advance)
//   s_a_i          dividend
//   s_b_i          divisor
//   s_signed_i     1 = two's-complement operands (ignored when SIGNED_EN = 0)
//   s_tag_i        user tag, returned in order with the result
//   m_valid_o      result valid
//   m_ready_i      downstream accepts result
//   m_quotient_o   quotient (all ones on divide by zero)
//   m_remainder_o  remainder (the dividend on divide by zero)
//   m_tag_o        tag of this result
//   m_div0_o       divisor was zero
//   busy_o         any stage or the output register holds a valid operation
module net_div_pipe #(
  parameter int DW        = 32,
  parameter int N_PIPE    = 8,
  parameter int TW        = 4,
  parameter int SIGNED_EN = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          s_valid_i,
  output logic          s_ready_o,
  input  logic [DW-1:0] s_a_i,
  input  logic [DW-1:0] s_b_i,
  input  logic          s_signed_i,
  input  logic [TW-1:0] s_tag_i,
  output logic          m_valid_o,
  input  logic          m_ready_i,
  output logic [DW-1:0] m_quotient_o,
  output logic [DW-1:0] m_remainder_o,
  output logic [TW-1:0] m_tag_o,
  output logic          m_div0_o,
  output logic          busy_o
);

  localparam int BPS = DW / N_PIPE;
  localparam logic [DW-1:0] ONE_C = {{(DW-1){1'b0}}, 1'b1};

  // Two's-complement negation.
  function automatic logic [DW-1:0] neg(input logic [DW-1:0] x);
    return (~x) + ONE_C;
  endfunction

  // One group of BPS restoring-division steps, MSB first. The divisor is
  // shifted up to the current bit position in a 2*DW-bit word so the shift
  // never loses bits. Returns {quotient, partial remainder}.
  function automatic logic [2*DW-1:0] div_step(input logic [DW-1:0] rem,
                                               input logic [DW-1:0] quo,
                                               input logic [DW-1:0] dvs,
                                               input int            chunk);
    logic [2*DW-1:0] r_w;
    logic [2*DW-1:0] d_w;
    logic [DW-1:0]   q_w;
    int              bit_idx;
    r_w = {{DW{1'b0}}, rem};
    q_w = quo;
    for (int k = 0; k < BPS; k++) begin
      bit_idx = DW - 1 - chunk * BPS - k;
      d_w     = {{DW{1'b0}}, dvs} << bit_idx;
      if (r_w >= d_w) begin
        r_w = r_w - d_w;
        q_w = q_w | (ONE_C << bit_idx);
      end else begin
        r_w = r_w;
        q_w = q_w;
      end
    end
    return {q_w, r_w[DW-1:0]};
  endfunction

  // Per-stage state
  logic          vld_r [N_PIPE];
  logic [DW-1:0] rem_r [N_PIPE];
  logic [DW-1:0] quo_r [N_PIPE];
  logic [DW-1:0] dvs_r [N_PIPE];
  logic          sa_r  [N_PIPE];
  logic          sb_r  [N_PIPE];
  logic          dz_r  [N_PIPE];
  logic [TW-1:0] tag_r [N_PIPE];

  // Result of stage j's division group, consumed by stage j+1 / output
  logic [DW-1:0] nxt_rem_s [N_PIPE];
  logic [DW-1:0] nxt_quo_s [N_PIPE];

  logic          adv_s;
  logic          sgn_en_s;
  logic          in_sa_s;
  logic          in_sb_s;
  logic [DW-1:0] in_amag_s;
  logic [DW-1:0] in_bmag_s;
  logic          in_dz_s;
  logic [DW-1:0] fix_q_s;
  logic [DW-1:0] fix_r_s;
  logic          busy_s;

  // The pipe moves whenever the output slot is empty or being drained.
  assign adv_s     = ~m_valid_o | m_ready_i;
  assign s_ready_o = adv_s;

  // Input decode: sign flags, operand magnitudes and divide-by-zero flag.
  always_comb begin
    if (SIGNED_EN != 32'sd0) begin
      sgn_en_s = s_signed_i;
    end else begin
      sgn_en_s = 1'b0;
    end
    in_sa_s = sgn_en_s & s_a_i[DW-1];
    in_sb_s = sgn_en_s & s_b_i[DW-1];
    if (in_sa_s) begin
      in_amag_s = neg(s_a_i);
    end else begin
      in_amag_s = s_a_i;
    end
    if (in_sb_s) begin
      in_bmag_s = neg(s_b_i);
    end else begin
      in_bmag_s = s_b_i;
    end
    in_dz_s = (s_b_i == {DW{1'b0}});
  end

  for (genvar j = 0; j < N_PIPE; j++) begin : g_stage
    assign {nxt_quo_s[j], nxt_rem_s[j]} = div_step(rem_r[j], quo_r[j], dvs_r[j], j);

    if (j == 0) begin : g_in
      // Stage 0: register the decoded operation.
      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          vld_r[0] <= 1'b0;
          rem_r[0] <= {DW{1'b0}};
          quo_r[0] <= {DW{1'b0}};
          dvs_r[0] <= {DW{1'b0}};
          sa_r[0]  <= 1'b0;
          sb_r[0]  <= 1'b0;
          dz_r[0]  <= 1'b0;
          tag_r[0] <= {TW{1'b0}};
        end else if (adv_s) begin
          vld_r[0] <= s_valid_i;
          rem_r[0] <= in_amag_s;
          quo_r[0] <= {DW{1'b0}};
          dvs_r[0] <= in_bmag_s;
          sa_r[0]  <= in_sa_s;
          sb_r[0]  <= in_sb_s;
          dz_r[0]  <= in_dz_s;
          tag_r[0] <= s_tag_i;
        end
      end
    end else begin : g_mid
      // Stage j: take the previous stage after its division group.
      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          vld_r[j] <= 1'b0;
          rem_r[j] <= {DW{1'b0}};
          quo_r[j] <= {DW{1'b0}};
          dvs_r[j] <= {DW{1'b0}};
          sa_r[j]  <= 1'b0;
          sb_r[j]  <= 1'b0;
          dz_r[j]  <= 1'b0;
          tag_r[j] <= {TW{1'b0}};
        end else if (adv_s) begin
          vld_r[j] <= vld_r[j-1];
          rem_r[j] <= nxt_rem_s[j-1];
          quo_r[j] <= nxt_quo_s[j-1];
          dvs_r[j] <= dvs_r[j-1];
          sa_r[j]  <= sa_r[j-1];
          sb_r[j]  <= sb_r[j-1];
          dz_r[j]  <= dz_r[j-1];
          tag_r[j] <= tag_r[j-1];
        end
      end
    end
  end

  // Sign fixup of the final magnitudes. Divide by zero forces an all-ones
  // quotient; the remainder then equals |a| re-signed, i.e. the dividend.
  always_comb begin
    if (dz_r[N_PIPE-1]) begin
      fix_q_s = {DW{1'b1}};
    end else if (sa_r[N_PIPE-1] ^ sb_r[N_PIPE-1]) begin
      fix_q_s = neg(nxt_quo_s[N_PIPE-1]);
    end else begin
      fix_q_s = nxt_quo_s[N_PIPE-1];
    end
    if (sa_r[N_PIPE-1]) begin
      fix_r_s = neg(nxt_rem_s[N_PIPE-1]);
    end else begin
      fix_r_s = nxt_rem_s[N_PIPE-1];
    end
  end

  // Output register: result fields only update when a valid op arrives.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      m_valid_o     <= 1'b0;
      m_quotient_o  <= {DW{1'b0}};
      m_remainder_o <= {DW{1'b0}};
      m_tag_o       <= {TW{1'b0}};
      m_div0_o      <= 1'b0;
    end else if (adv_s) begin
      m_valid_o <= vld_r[N_PIPE-1];
      if (vld_r[N_PIPE-1]) begin
        m_quotient_o  <= fix_q_s;
        m_remainder_o <= fix_r_s;
        m_tag_o       <= tag_r[N_PIPE-1];
        m_div0_o      <= dz_r[N_PIPE-1];
      end
    end
  end

  // Busy: OR of every stage valid bit and the output valid.
  always_comb begin
    busy_s = m_valid_o;
    for (int j = 0; j < N_PIPE; j++) begin
      busy_s = busy_s | vld_r[j];
    end
  end

  assign busy_o = busy_s;

endmodule

// File: tb/tb_net_div_pipe.sv
// Self-checking bench for net_div_pipe (DW=32, N_PIPE=8, TW=4, SIGNED_EN=1).
module tb_net_div_pipe;

  localparam int DW = 32;
  localparam int NP = 8;
  localparam int TW = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          s_valid_i;
  logic          s_ready_o;
  logic [DW-1:0] s_a_i;
  logic [DW-1:0] s_b_i;
  logic          s_signed_i;
  logic [TW-1:0] s_tag_i;
  logic          m_valid_o;
  logic          m_ready_i;
  logic [DW-1:0] m_quotient_o;
  logic [DW-1:0] m_remainder_o;
  logic [TW-1:0] m_tag_o;
  logic          m_div0_o;
  logic          busy_o;

  always #5 clk_i = ~clk_i;

  net_div_pipe #(.DW(DW), .N_PIPE(NP), .TW(TW), .SIGNED_EN(1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .s_a_i(s_a_i), .s_b_i(s_b_i), .s_signed_i(s_signed_i), .s_tag_i(s_tag_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_quotient_o(m_quotient_o), .m_remainder_o(m_remainder_o),
    .m_tag_o(m_tag_o), .m_div0_o(m_div0_o), .busy_o(busy_o)
  );

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic [3:0]  tag;
    logic        dz;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sg;
    logic [3:0]  tag;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  res_t exp_q[$];
  res_t held;
  bit   hold_q   = 1'b0;
  bit   last_acc = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   n_out = 0;
  vec_t tbl[8];

  // Reference: plain arithmetic from the division rules.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic sg, input logic [3:0] tag);
    res_t m;
    logic signed [31:0] sa_v;
    logic signed [31:0] sb_v;
    sa_v  = a;
    sb_v  = b;
    m.tag = tag;
    m.dz  = 1'b0;
    if (b == 32'd0) begin
      m.q = 32'hFFFF_FFFF; m.r = a; m.dz = 1'b1;
    end else if (!sg) begin
      m.q = a / b; m.r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      m.q = 32'h8000_0000; m.r = 32'd0;
    end else begin
      m.q = sa_v / sb_v; m.r = sa_v % sb_v;
    end
    return m;
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: settle, check handshake/stability/scoreboard, then advance.
  task automatic cycle();
    res_t got;
    bit   rst_now;
    #1;
    got     = {m_quotient_o, m_remainder_o, m_tag_o, m_div0_o};
    rst_now = rst_ni;
    if (rst_ni) begin
      check("s_ready", s_ready_o, !(m_valid_o && !m_ready_i));
      if (hold_q) check("stall stable", {m_valid_o, got}, {1'b1, held});
      if (m_valid_o && m_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected result", 1'b1, 1'b0);
        end else begin
          check("scoreboard", got, exp_q.pop_front());
          n_out++;
        end
      end
    end
    last_acc = rst_ni && s_valid_i && s_ready_o;
    if (last_acc) exp_q.push_back(model(s_a_i, s_b_i, s_signed_i, s_tag_i));
    hold_q = rst_ni && m_valid_o && !m_ready_i;
    held   = got;
    @(posedge clk_i);
    #1;
    if (!rst_now) begin
      exp_q.delete();
      hold_q = 1'b0;
    end
  endtask

  // Single op through an idle pipe: latency and fixed expected result.
  task automatic run_vec(input vec_t v, input string nm);
    int lat;
    s_valid_i = 1'b1; s_a_i = v.a; s_b_i = v.b; s_signed_i = v.sg; s_tag_i = v.tag;
    m_ready_i = 1'b1;
    cycle();
    check({nm, " accept"}, last_acc, 1'b1);
    s_valid_i = 1'b0;
    lat = 0;
    while (!m_valid_o && lat < 20) begin
      cycle();
      lat++;
    end
    check({nm, " latency"}, lat, NP);
    check({nm, " result"}, {m_quotient_o, m_remainder_o, m_tag_o, m_div0_o},
          {v.q, v.r, v.tag, v.dz});
    cycle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int out0;
    int stale;
    tbl[0] = '{32'd100,        32'd7,          1'b0, 4'd3, 32'd14,         32'd2,          1'b0};
    tbl[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 4'd5, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    tbl[2] = '{32'hFFFF_FFF9,  32'd2,          1'b0, 4'd6, 32'h7FFF_FFFC,  32'd1,          1'b0};
    tbl[3] = '{32'd5,          32'd0,          1'b0, 4'd7, 32'hFFFF_FFFF,  32'd5,          1'b1};
    tbl[4] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 4'd8, 32'h8000_0000,  32'd0,          1'b0};
    tbl[5] = '{32'hFFFF_FFF9,  32'd0,          1'b1, 4'd9, 32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1};
    tbl[6] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 4'd10, 32'hFFFF_FFFD, 32'd1,          1'b0};
    tbl[7] = '{32'd9,          32'd3,          1'b0, 4'd11, 32'd3,         32'd0,          1'b0};

    rst_ni = 1'b0; s_valid_i = 1'b0; s_a_i = 32'd0; s_b_i = 32'd0;
    s_signed_i = 1'b0; s_tag_i = 4'd0; m_ready_i = 1'b1;
    cycle();
    cycle();
    check("reset outputs", {m_valid_o, m_quotient_o, m_remainder_o, m_tag_o, m_div0_o, busy_o}, 80'd0);
    rst_ni = 1'b1;
    cycle();
    check("idle ready", s_ready_o, 1'b1);

    // Directed vectors
    for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Random stream with ~50% backpressure, tags in sequence
    out0 = n_out;
    for (int i = 0; i < 64; i++) begin
      s_valid_i = 1'b1; s_a_i = rnd_op(); s_b_i = rnd_op();
      s_signed_i = ($urandom_range(0, 1) != 0); s_tag_i = i[3:0];
      guard = 0;
      do begin
        m_ready_i = ($urandom_range(0, 1) != 0);
        cycle();
        guard++;
      end while (!last_acc && guard < 200);
      check("stream accept", last_acc, 1'b1);
    end
    s_valid_i = 1'b0; m_ready_i = 1'b1; guard = 0;
    while ((exp_q.size() != 0 || m_valid_o) && guard < 50) begin
      cycle();
      guard++;
    end
    check("stream count", n_out - out0, 64);
    check("stream drained", exp_q.size(), 0);
    check("stream idle busy", busy_o, 1'b0);

    // Full throughput: 32 back-to-back ops -> 32 consecutive valid cycles
    for (int c = 0; c < 50; c++) begin
      if (c < 32) begin
        s_valid_i = 1'b1; s_a_i = $urandom(); s_b_i = rnd_op();
        s_signed_i = ($urandom_range(0, 1) != 0); s_tag_i = c[3:0];
      end else begin
        s_valid_i = 1'b0;
      end
      cycle();
      check($sformatf("tput c%0d", c), m_valid_o, (c >= NP && c < NP + 32));
    end
    cycle();
    check("tput drained", exp_q.size(), 0);

    // Reset with four ops in flight
    for (int i = 0; i < 4; i++) begin
      s_valid_i = 1'b1; s_a_i = $urandom(); s_b_i = rnd_op(); s_signed_i = 1'b0; s_tag_i = 4'(i);
      cycle();
    end
    s_valid_i = 1'b0;
    check("busy before reset", busy_o, 1'b1);
    rst_ni = 1'b0;
    cycle();
    rst_ni = 1'b1;
    check("mid reset outputs", {m_valid_o, m_quotient_o, m_remainder_o, m_tag_o, m_div0_o, busy_o}, 80'd0);
    stale = 0;
    for (int i = 0; i < 15; i++) begin
      cycle();
      if (m_valid_o) stale++;
    end
    check("no stale result", stale, 0);
    run_vec(tbl[7], "post reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
